m65c02_bus_responder: RTL and testbench

Memory-side responder for the M65C02A core bus: it decodes `IO_Op`/`AO` into RAM, ROM and IO chip selects, and inserts per-region wait states on `Wait`. It returns read data on `DI` and generates SRAM-style strobes. It also extends IO cycles on an external ready and times out hung IO cycles with a sticky bus-error flag. It sits between the core (or its IOB-registered top wrapper) and board memory/peripherals.

---
 rtl/m65c02_bus_responder_pkg.sv | 29 ++
 rtl/m65c02_bus_responder_addrdec.sv | 29 ++
 rtl/m65c02_bus_responder.sv | 128 ++++++++++++
 tb/tb_m65c02_bus_responder.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/m65c02_bus_responder_pkg.sv
// Shared encodings for the M65C02A core bus: op codes, region codes and
// responder FSM states.
package M65C02_Pkg;

  localparam logic [1:0] pNOP = 2'b00;
  localparam logic [1:0] pWR  = 2'b01;
  localparam logic [1:0] pRD  = 2'b10;
  localparam logic [1:0] pIF  = 2'b11;

  localparam int unsigned CNT_W = 3;
  localparam int unsigned TMO_W = 8;

  typedef enum logic [1:0] {
    pRAM = 2'd0,
    pROM = 2'd1,
    pIO  = 2'd2
  } region_t;

  typedef enum logic {
    pIDLE = 1'b0,
    pWAIT = 1'b1
  } state_t;

  // RD and IF both drive the data bus toward the core.
  function automatic logic is_read(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/m65c02_bus_responder_addrdec.sv
// Address decoder: maps AO to a memory region and that region's wait count.
module M65C02_AddrDec
  import M65C02_Pkg::*;
#(
  parameter int unsigned RAM_WS   = 0,
  parameter int unsigned ROM_WS   = 1,
  parameter int unsigned IO_WS    = 2,
  parameter logic [3:0]  ROM_BASE = 4'hC,
  parameter logic [7:0]  IO_PAGE  = 8'hFE
) (
  input  logic [15:0]      i_ao,
  output region_t          o_rgn,
  output logic [CNT_W-1:0] o_ws
);

  // IO page wins over ROM, ROM wins over RAM.
  always_comb begin
    o_rgn = pRAM;
    o_ws  = CNT_W'(RAM_WS);
    if (i_ao[15:8] == IO_PAGE) begin
      o_rgn = pIO;
      o_ws  = CNT_W'(IO_WS);
    end else if (i_ao[15:12] >= ROM_BASE) begin
      o_rgn = pROM;
      o_ws  = CNT_W'(ROM_WS);
    end
  end

endmodule

// File: rtl/m65c02_bus_responder.sv
// Memory-side bus responder: chip selects, SRAM strobes, per-region wait
// states, IO ready extension and sticky IO timeout flag.
module m65c02_bus_responder
  import M65C02_Pkg::*;
#(
  parameter int unsigned RAM_WS   = 0,
  parameter int unsigned ROM_WS   = 1,
  parameter int unsigned IO_WS    = 2,
  parameter logic [3:0]  ROM_BASE = 4'hC,
  parameter logic [7:0]  IO_PAGE  = 8'hFE,
  parameter int unsigned TMO      = 63
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [1:0]  IO_Op,
  input  logic [15:0] AO,
  input  logic [7:0]  DO,
  output logic        Wait,
  output logic [7:0]  DI,
  output logic        nCE_RAM,
  output logic        nCE_ROM,
  output logic        nCE_IO,
  output logic        nOE,
  output logic        nWE,
  output logic [15:0] MA,
  output logic [7:0]  MD_O,
  input  logic [7:0]  MD_I,
  input  logic        xRdy,
  output logic        BusErr
);

  state_t            r_state, w_state_nxt;
  region_t           r_rgn, w_rgn_nxt, w_dec_rgn, w_rgn_act;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt, w_dec_ws;
  logic [TMO_W-1:0]  r_tmo, w_tmo_nxt;
  logic              r_buserr, w_buserr_nxt;
  logic              w_op, w_io_hold, w_forced, w_wait, w_act;

  M65C02_AddrDec #(
    .RAM_WS  (RAM_WS),
    .ROM_WS  (ROM_WS),
    .IO_WS   (IO_WS),
    .ROM_BASE(ROM_BASE),
    .IO_PAGE (IO_PAGE)
  ) u_addrdec (
    .i_ao (AO),
    .o_rgn(w_dec_rgn),
    .o_ws (w_dec_ws)
  );

  assign w_op = (IO_Op != pNOP);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state  <= pIDLE;
      r_rgn    <= pRAM;
      r_cnt    <= '0;
      r_tmo    <= '0;
      r_buserr <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_rgn    <= w_rgn_nxt;
      r_cnt    <= w_cnt_nxt;
      r_tmo    <= w_tmo_nxt;
      r_buserr <= w_buserr_nxt;
    end
  end

  // Next state, wait-state counting and timeout detection.
  always_comb begin
    w_state_nxt  = r_state;
    w_rgn_nxt    = r_rgn;
    w_cnt_nxt    = r_cnt;
    w_tmo_nxt    = r_tmo;
    w_buserr_nxt = r_buserr;
    w_rgn_act    = w_dec_rgn;
    w_io_hold    = 1'b0;
    w_wait       = 1'b0;
    w_forced     = 1'b0;
    unique case (r_state)
      pIDLE: begin
        if (w_op && (w_dec_ws != '0)) begin
          w_wait      = 1'b1;
          w_cnt_nxt   = w_dec_ws - CNT_W'(1);
          w_rgn_nxt   = w_dec_rgn;
          w_tmo_nxt   = '0;
          w_state_nxt = pWAIT;
        end
      end
      pWAIT: begin
        w_rgn_act = r_rgn;
        w_io_hold = (r_rgn == pIO) && !xRdy;
        w_wait    = (r_cnt != '0) || (w_io_hold && (r_tmo != TMO_W'(TMO)));
        w_forced  = !w_wait && w_io_hold;
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else if (r_rgn == pIO) begin
          w_tmo_nxt = r_tmo + TMO_W'(1);
        end
        if (!w_wait) begin
          w_state_nxt = pIDLE;
          if (w_forced) w_buserr_nxt = 1'b1;
        end
      end
      default: w_state_nxt = pIDLE;
    endcase
    if (Rst) begin
      w_wait   = 1'b0;
      w_forced = 1'b0;
    end
  end

  // Strobes and selects are suppressed in the reset cycle.
  assign w_act   = w_op && !Rst;
  assign Wait    = w_wait;
  assign nCE_RAM = !(w_act && (w_rgn_act == pRAM));
  assign nCE_ROM = !(w_act && (w_rgn_act == pROM));
  assign nCE_IO  = !(w_act && (w_rgn_act == pIO));
  assign nOE     = !(w_act && is_read(IO_Op));
  assign nWE     = !(w_act && (IO_Op == pWR) && (w_rgn_act != pROM));
  assign DI      = Rst      ? 8'h00 :
                   w_forced ? 8'hFF :
                   is_read(IO_Op) ? MD_I : 8'h00;
  assign MA      = AO;
  assign MD_O    = DO;
  assign BusErr  = r_buserr;

endmodule

// File: tb/tb_m65c02_bus_responder.sv
// Bench for m65c02_bus_responder: directed bus cycles checked every cycle
// against a cycle-count model of the bus protocol, plus literal expectations.
module tb_m65c02_bus_responder;

  localparam int unsigned RAM_WS = 0;
  localparam int unsigned ROM_WS = 1;
  localparam int unsigned IO_WS  = 2;
  localparam int unsigned TMO    = 63;
  localparam logic [1:0] OP_NOP = 2'b00, OP_WR = 2'b01, OP_RD = 2'b10, OP_IF = 2'b11;
  localparam int R_RAM = 0, R_ROM = 1, R_IO = 2;

  logic        Clk, Rst, Wait, nCE_RAM, nCE_ROM, nCE_IO, nOE, nWE, xRdy, BusErr;
  logic [1:0]  IO_Op;
  logic [15:0] AO, MA;
  logic [7:0]  DO, DI, MD_O, MD_I;

  int n_pass = 0;
  int n_chk  = 0;

  m65c02_bus_responder #(
    .RAM_WS(RAM_WS), .ROM_WS(ROM_WS), .IO_WS(IO_WS),
    .ROM_BASE(4'hC), .IO_PAGE(8'hFE), .TMO(TMO)
  ) dut (
    .Clk(Clk), .Rst(Rst), .IO_Op(IO_Op), .AO(AO), .DO(DO), .Wait(Wait), .DI(DI),
    .nCE_RAM(nCE_RAM), .nCE_ROM(nCE_ROM), .nCE_IO(nCE_IO), .nOE(nOE), .nWE(nWE),
    .MA(MA), .MD_O(MD_O), .MD_I(MD_I), .xRdy(xRdy), .BusErr(BusErr)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // Model: a bus cycle is just "cycles elapsed since it started".
  int   m_e = 0;
  logic m_berr = 1'b0;
  logic m_fin = 1'b0;
  logic m_forced = 1'b0;

  function automatic int region_of(input logic [15:0] a);
    if (a[15:8] == 8'hFE) return R_IO;
    if (a[15:12] >= 4'hC) return R_ROM;
    return R_RAM;
  endfunction

  function automatic int ws_of(input int r);
    if (r == R_IO) return int'(IO_WS);
    if (r == R_ROM) return int'(ROM_WS);
    return int'(RAM_WS);
  endfunction

  always @(negedge Clk) begin
    int   r;
    logic op, act, ew, ef;
    logic [7:0] edi;
    r   = region_of(AO);
    op  = (IO_Op != OP_NOP);
    act = op && !Rst;
    ew  = act && ((m_e < ws_of(r)) ||
                  (r == R_IO && !xRdy && m_e < int'(IO_WS + TMO)));
    ef  = act && !ew && r == R_IO && !xRdy;
    edi = Rst ? 8'h00 : ef ? 8'hFF : IO_Op[1] ? MD_I : 8'h00;
    check("m_wait",    32'(Wait),    32'(ew));
    check("m_nce_ram", 32'(nCE_RAM), 32'(!(act && r == R_RAM)));
    check("m_nce_rom", 32'(nCE_ROM), 32'(!(act && r == R_ROM)));
    check("m_nce_io",  32'(nCE_IO),  32'(!(act && r == R_IO)));
    check("m_noe",     32'(nOE),     32'(!(act && IO_Op[1])));
    check("m_nwe",     32'(nWE),     32'(!(act && IO_Op == OP_WR && r != R_ROM)));
    check("m_di",      32'(DI),      32'(edi));
    check("m_buserr",  32'(BusErr),  32'(m_berr));
    check("m_ma",      32'(MA),      32'(AO));
    check("m_md_o",    32'(MD_O),    32'(DO));
    m_fin    = act && !ew;
    m_forced = ef;
  end

  always @(posedge Clk) begin
    if (Rst) begin
      m_e    <= 0;
      m_berr <= 1'b0;
    end else if (IO_Op != OP_NOP) begin
      m_e <= m_fin ? 0 : m_e + 1;
      if (m_forced) m_berr <= 1'b1;
    end
  end

  // Drive one bus op until completion; xRdy held low for the first xlow cycles.
  task automatic run_op(input logic [1:0] op, input logic [15:0] a, input logic [7:0] d,
                        input logic [7:0] mdi, input int xlow,
                        output int waits, output logic [7:0] di_c, output logic nwe_c);
    logic done;
    IO_Op = op; AO = a; DO = d; MD_I = mdi; xRdy = (xlow == 0);
    waits = 0; done = 1'b0; di_c = 8'h00; nwe_c = 1'b1;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge Clk);
      if (!Wait) begin
        di_c = DI; nwe_c = nWE; done = 1'b1;
      end else begin
        waits++;
      end
      @(posedge Clk); #1;
      xRdy = (waits >= xlow);
    end
    if (!done) check("wait_bound", 32'(done), 32'(1));
  endtask

  task automatic idle(input int n);
    IO_Op = OP_NOP; xRdy = 1'b1;
    repeat (n) begin @(posedge Clk); #1; end
  endtask

  int         w;
  logic [7:0] di;
  logic       nwe;

  initial begin
    Rst = 1'b1; IO_Op = OP_RD; AO = 16'h0200; DO = 8'h00; MD_I = 8'h33; xRdy = 1'b1;
    @(negedge Clk);
    check("rst_wait",    32'(Wait),    32'(0));
    check("rst_nce_ram", 32'(nCE_RAM), 32'(1));
    check("rst_noe",     32'(nOE),     32'(1));
    check("rst_di",      32'(DI),      32'h00);
    check("rst_buserr",  32'(BusErr),  32'(0));
    @(posedge Clk); #1;
    IO_Op = OP_NOP;
    @(posedge Clk); #1;
    Rst = 1'b0;
    idle(1);

    run_op(OP_RD, 16'h0200, 8'h00, 8'h5A, 0, w, di, nwe);
    check("ram_rd_waits", 32'(w), 32'(0));
    check("ram_rd_di", 32'(di), 32'h5A);
    run_op(OP_IF, 16'hFFFC, 8'h00, 8'hA9, 0, w, di, nwe);
    check("rom_if_waits", 32'(w), 32'(1));
    check("rom_if_di", 32'(di), 32'hA9);
    run_op(OP_WR, 16'hC000, 8'h77, 8'h00, 0, w, di, nwe);
    check("rom_wr_waits", 32'(w), 32'(1));
    check("rom_wr_nwe", 32'(nwe), 32'(1));
    idle(2);

    run_op(OP_RD, 16'hFE10, 8'h00, 8'hC3, 5, w, di, nwe);
    check("io_xrdy_waits", 32'(w), 32'(5));
    check("io_xrdy_di", 32'(di), 32'hC3);
    IO_Op = OP_NOP; xRdy = 1'b1;
    @(negedge Clk);
    check("io_xrdy_buserr", 32'(BusErr), 32'(0));
    @(posedge Clk); #1;

    run_op(OP_WR, 16'h0010, 8'h42, 8'h00, 0, w, di, nwe);
    check("b2b_ram_waits", 32'(w), 32'(0));
    check("b2b_ram_nwe", 32'(nwe), 32'(0));
    run_op(OP_RD, 16'hC123, 8'h00, 8'h9E, 0, w, di, nwe);
    check("b2b_rom_waits", 32'(w), 32'(1));
    run_op(OP_RD, 16'hFE20, 8'h00, 8'h3C, 0, w, di, nwe);
    check("b2b_io_waits", 32'(w), 32'(2));
    check("b2b_io_di", 32'(di), 32'h3C);
    idle(2);

    run_op(OP_RD, 16'hFE30, 8'h00, 8'h12, 1000, w, di, nwe);
    check("tmo_waits", 32'(w), 32'(65));
    check("tmo_di", 32'(di), 32'hFF);
    IO_Op = OP_NOP; xRdy = 1'b1;
    @(negedge Clk);
    check("tmo_buserr", 32'(BusErr), 32'(1));
    @(posedge Clk); #1;
    run_op(OP_RD, 16'h0300, 8'h00, 8'h66, 0, w, di, nwe);
    idle(3);
    @(negedge Clk);
    check("tmo_buserr_sticky", 32'(BusErr), 32'(1));
    @(posedge Clk); #1;

    // Reset lands in the first WAIT cycle of an IO read (cnt still 1).
    IO_Op = OP_RD; AO = 16'hFE10; MD_I = 8'h11; xRdy = 1'b1;
    @(posedge Clk); #1;
    Rst = 1'b1;
    @(negedge Clk);
    check("rmid_wait",   32'(Wait),   32'(0));
    check("rmid_nce_io", 32'(nCE_IO), 32'(1));
    check("rmid_noe",    32'(nOE),    32'(1));
    check("rmid_di",     32'(DI),     32'h00);
    @(posedge Clk); #1;
    Rst = 1'b0; IO_Op = OP_NOP;
    @(negedge Clk);
    check("rmid_after_wait",   32'(Wait),   32'(0));
    check("rmid_after_buserr", 32'(BusErr), 32'(0));
    @(posedge Clk); #1;
    run_op(OP_RD, 16'hFFFC, 8'h00, 8'hD5, 0, w, di, nwe);
    check("rmid_rom_waits", 32'(w), 32'(1));
    check("rmid_rom_di", 32'(di), 32'hD5);
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
